// File: rtl/booth_mult_arbiter.sv
// Round-robin front end sharing one 16x16 signed radix-4 Booth multiplier among
// NUM_REQ requesters, with a two-stage (capture, product) valid/ready pipeline.
module booth_mult_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [16*NUM_REQ-1:0]   req_a,
  input  logic [16*NUM_REQ-1:0]   req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_product,
  output logic                    busy
);

  // Radix-4 Booth: eight partial products selected from {0, +-a, +-2a}, each
  // weighted by 4^i; summing modulo 2^32 yields the exact signed product.
  function automatic logic [31:0] booth_mul(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] bx;
    logic [31:0] a_ext;
    logic [31:0] pp;
    logic [31:0] acc;
    logic [2:0]  grp;
    bx    = {b, 1'b0};
    a_ext = {{16{a[15]}}, a};
    acc   = 32'd0;
    for (int i = 0; i < 8; i++) begin
      grp = bx[2*i +: 3];
      case (grp)
        3'b000, 3'b111: pp = 32'd0;
        3'b001, 3'b010: pp = a_ext;
        3'b011:         pp = a_ext << 1;
        3'b100:         pp = -(a_ext << 1);
        3'b101, 3'b110: pp = -a_ext;
        default:        pp = 32'd0;
      endcase
      acc = acc + (pp << (2*i));
    end
    return acc;
  endfunction

  logic              s1_valid_r;
  logic [15:0]       s1_a_r;
  logic [15:0]       s1_b_r;
  logic [ID_W-1:0]   s1_id_r;
  logic              s2_valid_r;
  logic [ID_W-1:0]   s2_id_r;
  logic [31:0]       s2_product_r;
  logic [ID_W-1:0]   rr_ptr_r;

  logic              s2_load_s;
  logic              s1_free_s;
  logic              grant_found_s;
  logic [ID_W-1:0]   grant_idx_s;
  logic [ID_W-1:0]   ptr_next_s;
  logic              req_hs_s;
  logic [15:0]       sel_a_s;
  logic [15:0]       sel_b_s;

  assign s2_load_s = s1_valid_r & (~s2_valid_r | rsp_ready);
  assign s1_free_s = ~s1_valid_r | s2_load_s;
  assign req_hs_s  = s1_free_s & grant_found_s & ~rst;
  assign sel_a_s   = req_a[16*grant_idx_s +: 16];
  assign sel_b_s   = req_b[16*grant_idx_s +: 16];
  assign ptr_next_s = (grant_idx_s == ID_W'(NUM_REQ-1)) ? {ID_W{1'b0}} : grant_idx_s + ID_W'(1);

  // Cyclic search from rr_ptr; walking downward lets the nearest valid requester win.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = {ID_W{1'b0}};
    for (int off = NUM_REQ-1; off >= 0; off--) begin
      grant_found_s = grant_found_s | req_valid[(int'(rr_ptr_r) + off) % NUM_REQ];
      grant_idx_s   = req_valid[(int'(rr_ptr_r) + off) % NUM_REQ] ?
                      ID_W'((int'(rr_ptr_r) + off) % NUM_REQ) : grant_idx_s;
    end
  end

  // One-hot grant, held low during reset and whenever S1 cannot take new data.
  always_comb begin
    req_ready = {NUM_REQ{1'b0}};
    if (req_hs_s) begin
      req_ready[grant_idx_s] = 1'b1;
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
  end

  // Operand capture stage and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= 16'd0;
      s1_b_r     <= 16'd0;
      s1_id_r    <= {ID_W{1'b0}};
      rr_ptr_r   <= {ID_W{1'b0}};
    end else begin
      if (s1_free_s) begin
        s1_valid_r <= req_hs_s;
      end
      if (req_hs_s) begin
        s1_a_r   <= sel_a_s;
        s1_b_r   <= sel_b_s;
        s1_id_r  <= grant_idx_s;
        rr_ptr_r <= ptr_next_s;
      end
    end
  end

  // Product stage; a reload in the same cycle as an accept replaces data with no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_r   <= 1'b0;
      s2_id_r      <= {ID_W{1'b0}};
      s2_product_r <= 32'd0;
    end else if (s2_load_s) begin
      s2_valid_r   <= 1'b1;
      s2_id_r      <= s1_id_r;
      s2_product_r <= booth_mul(s1_a_r, s1_b_r);
    end else if (rsp_ready) begin
      s2_valid_r   <= 1'b0;
    end
  end

  assign rsp_valid   = s2_valid_r;
  assign rsp_id      = s2_id_r;
  assign rsp_product = s2_product_r;
  assign busy        = s1_valid_r | s2_valid_r;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed bench for booth_mult_arbiter: a transaction-level queue model checks
// every cycle, and literal expectations pin grant order, latency and products.
module tb_booth_mult_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_product;
  logic        busy;

  booth_mult_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_product(rsp_product), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_rsp = 0;
  // Model: in-flight products in grant order with their acceptance cycle.
  logic [31:0] m_prod[$];
  logic [1:0]  m_id[$];
  int          m_t[$];
  int          m_ptr = 0;
  // Observed DUT history used by the pinned checks.
  int          grant_log[$];
  int          rsp_log[$];
  int          rsp_cyc[$];
  logic [31:0] prod_log[$];
  logic [31:0] last_prod;
  logic [1:0]  last_id;
  logic [3:0]  acc;

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] x;
    logic signed [31:0] y;
    x = $signed(a);
    y = $signed(b);
    return x * y;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic set_req(input int k, input logic [15:0] a, input logic [15:0] b);
    req_a[16*k +: 16] = a;
    req_b[16*k +: 16] = b;
  endtask

  // One clock cycle: compare at negedge, advance the model, return at posedge+1.
  task automatic tick(output logic [3:0] accepted);
    int   g;
    int   idx;
    logic exp_rv;
    logic [3:0] exp_rdy;
    @(negedge clk);
    accepted = 4'b0000;
    if (rst) begin
      m_prod.delete(); m_id.delete(); m_t.delete(); m_ptr = 0;
      chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
      chk("rst_rsp_product", rsp_product, 32'd0);
    end else begin
      g = -1;
      exp_rdy = 4'b0000;
      if (m_prod.size() < 2 || rsp_ready) begin
        for (int off = 0; off < 4; off++) begin
          idx = (m_ptr + off) % 4;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      exp_rv = 1'b0;
      if (m_prod.size() > 0) exp_rv = (cyc >= m_t[0] + 2);
      chk("req_ready", {28'd0, req_ready}, {28'd0, exp_rdy});
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_rv});
      chk("busy", {31'd0, busy}, {31'd0, (m_prod.size() > 0)});
      if (exp_rv) begin
        chk("rsp_id", {30'd0, rsp_id}, {30'd0, m_id[0]});
        chk("rsp_product", rsp_product, m_prod[0]);
      end
      for (int k = 0; k < 4; k++) if (req_ready[k] && req_valid[k]) grant_log.push_back(k);
      if (rsp_valid && rsp_ready) begin
        rsp_log.push_back(int'(rsp_id)); rsp_cyc.push_back(cyc); prod_log.push_back(rsp_product);
        last_prod = rsp_product; last_id = rsp_id; n_rsp++;
      end
      if (exp_rv && rsp_ready) begin
        void'(m_prod.pop_front()); void'(m_id.pop_front()); void'(m_t.pop_front());
      end
      if (g >= 0) begin
        m_prod.push_back(ref_mul(req_a[16*g +: 16], req_b[16*g +: 16]));
        m_id.push_back(2'(g));
        m_t.push_back(cyc);
        m_ptr = (g + 1) % 4;
        accepted = exp_rdy;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(acc);
    tick(acc);
    rst = 1'b0;
  endtask

  task automatic wait_rsp(input string nm, input int target);
    for (int i = 0; i < 20 && n_rsp < target; i++) tick(acc);
    chk(nm, n_rsp, target);
  endtask

  task automatic issue(input int k, input logic [15:0] a, input logic [15:0] b);
    set_req(k, a, b);
    req_valid[k] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(acc);
      if (acc[k]) break;
    end
    req_valid[k] = 1'b0;
    chk("issue_accept", {31'd0, acc[k]}, 32'd1);
  endtask

  logic [15:0] ca[4] = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000};
  logic [15:0] cb[4] = '{16'h8000, 16'h0001, 16'h7FFF, 16'h1234};
  logic [31:0] ce[4] = '{32'h40000000, 32'hFFFFFFFF, 32'h3FFF0001, 32'h00000000};

  initial begin
    int hs_cyc;
    int base;
    int gj[4];
    int j;
    int acc_count;
    rst = 1'b1; req_valid = 4'b0000; req_a = 64'd0; req_b = 64'd0; rsp_ready = 1'b1;

    // Reset, then a single request from requester 2.
    do_reset();
    set_req(2, 16'd3, 16'hFFFB);
    req_valid = 4'b0100;
    grant_log.delete();
    tick(acc);
    hs_cyc = cyc - 1;
    req_valid = 4'b0000;
    chk("t1_grant_count", grant_log.size(), 32'd1);
    if (grant_log.size() > 0) chk("t1_grant", grant_log[0], 32'd2);
    wait_rsp("t1_rsp", 1);
    chk("t1_id", {30'd0, last_id}, 32'd2);
    chk("t1_product", last_prod, 32'hFFFFFFF1);
    if (rsp_cyc.size() > 0) chk("t1_latency", rsp_cyc[$] - hs_cyc, 32'd2);

    // Corner operands through requester 0.
    for (int i = 0; i < 4; i++) begin
      base = n_rsp;
      issue(0, ca[i], cb[i]);
      wait_rsp("corner_rsp", base + 1);
      chk("corner_id", {30'd0, last_id}, 32'd0);
      chk("corner_product", last_prod, ce[i]);
    end

    // All four requesters continuously valid for eight cycles.
    do_reset();
    grant_log.delete(); rsp_log.delete(); rsp_cyc.delete();
    base = n_rsp;
    for (int k = 0; k < 4; k++) begin
      gj[k] = 0;
      set_req(k, 16'(k*4097), 16'(-k*12345 - 1));
    end
    req_valid = 4'b1111;
    repeat (8) begin
      tick(acc);
      for (int k = 0; k < 4; k++) if (acc[k]) begin
        gj[k]++;
        set_req(k, 16'(k*4097 - gj[k]*911), 16'(gj[k]*3001 - k*12345 - 1));
      end
    end
    req_valid = 4'b0000;
    wait_rsp("rr_rsp", base + 8);
    chk("rr_grant_count", grant_log.size(), 32'd8);
    if (grant_log.size() >= 8 && rsp_log.size() >= 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("rr_grant_order", grant_log[i], i % 4);
        chk("rr_rsp_order", rsp_log[i], i % 4);
      end
      chk("rr_back_to_back", rsp_cyc[7] - rsp_cyc[0], 32'd7);
    end

    // Backpressure with three pending requests.
    do_reset();
    grant_log.delete(); rsp_log.delete();
    rsp_ready = 1'b0;
    set_req(0, 16'd100, 16'd200);
    set_req(1, 16'hFFF9, 16'd9);
    set_req(2, 16'd1234, 16'hFFFE);
    req_valid = 4'b0111;
    repeat (5) begin
      tick(acc);
      req_valid = req_valid & ~acc;
    end
    chk("bp_accepted", grant_log.size(), 32'd2);
    chk("bp_req_ready", {28'd0, req_ready}, 32'd0);
    chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("bp_hold_id", {30'd0, rsp_id}, 32'd0);
    chk("bp_hold_product", rsp_product, 32'h00004E20);
    rsp_ready = 1'b1;
    for (int i = 0; i < 12 && rsp_log.size() < 3; i++) begin
      tick(acc);
      req_valid = req_valid & ~acc;
    end
    chk("bp_rsp_count", rsp_log.size(), 32'd3);
    if (rsp_log.size() >= 3 && grant_log.size() >= 3) begin
      for (int i = 0; i < 3; i++) chk("bp_rsp_order", rsp_log[i], i);
      chk("bp_third_grant", grant_log[2], 32'd2);
      chk("bp_third_product", prod_log[prod_log.size()-1], 32'hFFFFF65C);
    end

    // Reset while both stages hold data.
    rsp_ready = 1'b0;
    set_req(3, 16'd5, 16'd6);
    set_req(0, 16'd7, 16'd8);
    req_valid = 4'b1001;
    repeat (3) begin
      tick(acc);
      req_valid = req_valid & ~acc;
    end
    chk("full_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    tick(acc);
    rst = 1'b0;
    rsp_ready = 1'b1;
    base = n_rsp;
    repeat (4) tick(acc);
    chk("no_stale_rsp", n_rsp, base);
    grant_log.delete();
    set_req(0, 16'd11, 16'd13);
    set_req(1, 16'd17, 16'd19);
    req_valid = 4'b0011;
    for (int i = 0; i < 10 && req_valid != 4'b0000; i++) begin
      tick(acc);
      req_valid = req_valid & ~acc;
    end
    req_valid = 4'b0000;
    if (grant_log.size() >= 2) begin
      chk("ptr_reset_first", grant_log[0], 32'd0);
      chk("ptr_reset_second", grant_log[1], 32'd1);
    end else begin
      chk("ptr_reset_grants", grant_log.size(), 32'd2);
    end
    wait_rsp("post_rst_rsp", base + 2);

    // Requester 1 streams ten operand pairs.
    base = n_rsp;
    j = 0;
    acc_count = 0;
    set_req(1, 16'(-5000), 16'd3000);
    req_valid = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      tick(acc);
      if (acc[1]) begin
        j++;
        acc_count++;
        if (j < 10) set_req(1, 16'(j*1111 - 5000), 16'(3000 - j*777));
        else req_valid = 4'b0000;
      end
    end
    req_valid = 4'b0000;
    chk("stream_accepts", acc_count, 32'd10);
    wait_rsp("stream_rsp", base + 10);
    if (rsp_cyc.size() >= 10 && n_rsp >= base + 10) begin
      chk("stream_consecutive", rsp_cyc[rsp_cyc.size()-1] - rsp_cyc[rsp_cyc.size()-10], 32'd9);
      chk("stream_first_product", prod_log[prod_log.size()-10], 32'hFF1B1E40);
    end

    repeat (3) tick(acc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
